unified_mem_arbiter: RTL

//  Shares one single-port synchronous SRAM (14-bit word address, 32-bit data) between the IF-stage

---
 rtl/unified_mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous SRAM between the fetch port and the data port.
// One transaction in flight; data port has priority, bounded by a fetch starvation counter.
`default_nettype none

module unified_mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [DATA_W-1:0] dm_bweb_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_bweb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int WCNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int SCNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT  = WCNT_W'(MEM_LATENCY);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(1);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] bweb_q, bweb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic [SCNT_W-1:0] starve_q, starve_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic w_idle;
  logic w_if_win;
  logic w_dm_win;

  // Grants are gated by reset so no port sees an acceptance while the block is held in reset.
  assign w_idle   = (state_q == S_IDLE) && rst_ni;
  assign w_if_win = w_idle && if_req_i && (!dm_req_i || (starve_q == STARVE_MAX));
  assign w_dm_win = w_idle && dm_req_i && !w_if_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    bweb_d      = bweb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_if_win) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          bweb_d  = '1;
          addr_d  = if_addr_i;
          state_d = S_ISSUE;
        end else if (w_dm_win) begin
          owner_d = OWN_DM;
          we_d    = dm_we_i;
          bweb_d  = dm_we_i ? dm_bweb_i : '1;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else begin
          wait_d = wait_q - WAIT_LAST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any cycle without a pending fetch means fetch is not being starved.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || w_if_win) begin
      starve_d = '0;
    end else if (w_dm_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      bweb_q      <= '1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      bweb_q      <= bweb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = w_if_win;
  assign dm_gnt_o    = w_dm_win;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_cs_o    = (state_q == S_ISSUE);
  assign mem_we_o    = (state_q == S_ISSUE) && we_q;
  assign mem_bweb_o  = (state_q == S_ISSUE) ? bweb_q : '1;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire
